// File: rtl/avmm_page_burst_splitter.sv
// ----------------------------------------------------------------------------
// avmm_page_burst_splitter
//
// Purpose:
//   Splits each upstream Avalon-MM burst (up to 2^(IN_BURST_W-1) lines) into
//   downstream sub-bursts in ascending address order. No sub-burst is longer
//   than OUT_MAX = 2^(OUT_BURST_W-1) lines, and none crosses a page of
//   2^PAGE_LINES_LOG2 lines. Addresses are line-granular.
//
//   Reads:  one downstream read command per sub-burst. The upstream read is
//           acknowledged (up_waitrequest low) on the cycle the final
//           sub-burst command is accepted. Read data passes straight back.
//   Writes: upstream write beats flow straight through. The downstream
//           address/burstcount are reloaded after the last beat of each
//           sub-burst.
//
// Ports:
//   pClk, pClk_reset         clock, synchronous active-high reset
//   up_*                     upstream Avalon-MM slave (command in, data back)
//   down_*                   downstream Avalon-MM master (command out)
// ----------------------------------------------------------------------------
module avmm_page_burst_splitter #(
   parameter int ADDR_WIDTH      = 42,
   parameter int DATA_WIDTH      = 512,
   parameter int IN_BURST_W      = 7,
   parameter int OUT_BURST_W     = 6,
   parameter int PAGE_LINES_LOG2 = 6
) (
   input  logic                      pClk,
   input  logic                      pClk_reset,
   // upstream slave
   input  logic [ADDR_WIDTH-1:0]     up_address,
   input  logic [IN_BURST_W-1:0]     up_burstcount,
   input  logic                      up_read,
   input  logic                      up_write,
   input  logic [DATA_WIDTH-1:0]     up_writedata,
   input  logic [DATA_WIDTH/8-1:0]   up_byteenable,
   output logic                      up_waitrequest,
   output logic [DATA_WIDTH-1:0]     up_readdata,
   output logic                      up_readdatavalid,
   // downstream master
   output logic [ADDR_WIDTH-1:0]     down_address,
   output logic [OUT_BURST_W-1:0]    down_burstcount,
   output logic                      down_read,
   output logic                      down_write,
   output logic [DATA_WIDTH-1:0]     down_writedata,
   output logic [DATA_WIDTH/8-1:0]   down_byteenable,
   input  logic                      down_waitrequest,
   input  logic [DATA_WIDTH-1:0]     down_readdata,
   input  logic                      down_readdatavalid
);

   localparam int OUT_MAX    = 1 << (OUT_BURST_W - 1);
   localparam int PAGE_LINES = 1 << PAGE_LINES_LOG2;
   // Counter width: must hold the full upstream burst and a full page.
   localparam int CW = (IN_BURST_W > PAGE_LINES_LOG2 + 1) ? IN_BURST_W : PAGE_LINES_LOG2 + 1;

   localparam logic [CW-1:0] OUT_MAX_C = CW'(OUT_MAX);
   localparam logic [CW-1:0] PAGE_C    = CW'(PAGE_LINES);

   // Reject parameter sets where a sub-burst could not be represented.
   if ((OUT_MAX > (1 << (PAGE_LINES_LOG2 - 1))) || (OUT_BURST_W > IN_BURST_W)) begin : g_bad_params
      $fatal(1, "avmm_page_burst_splitter: illegal OUT_BURST_W / IN_BURST_W / PAGE_LINES_LOG2 combination");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_SPLIT = 2'd1,
      WR_SPLIT = 2'd2
   } state_t;

   // Length of the sub-burst starting at a line with page offset offs:
   // min(remaining, OUT_MAX, lines left in the page).
   function automatic logic [CW-1:0] sub_len(input logic [PAGE_LINES_LOG2-1:0] offs,
                                             input logic [CW-1:0]              rem);
      logic [CW-1:0] room;
      logic [CW-1:0] len;
      room = PAGE_C - CW'(offs);
      if (rem > OUT_MAX_C) begin
         len = OUT_MAX_C;
      end else begin
         len = rem;
      end
      if (len > room) begin
         len = room;
      end else begin
         len = len;
      end
      return len;
   endfunction

   state_t                 state_q,     state_d;
   logic [ADDR_WIDTH-1:0]  addr_q,      addr_d;       // start of current sub-burst
   logic [CW-1:0]          rem_q,       rem_d;        // lines left, including current sub-burst
   logic [CW-1:0]          len_q,       len_d;        // length of current sub-burst
   logic [OUT_BURST_W-1:0] beat_q,      beat_d;       // write beats done in current sub-burst
   logic                   down_read_q, down_read_d;

   logic [CW-1:0]          rem_in_s;
   logic [ADDR_WIDTH-1:0]  next_addr_s;
   logic [CW-1:0]          next_rem_s;
   logic [OUT_BURST_W-1:0] beat_inc_s;
   logic                   last_sub_s;

   // Next-state, sub-burst sequencing and upstream handshake.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      rem_d          = rem_q;
      len_d          = len_q;
      beat_d         = beat_q;
      up_waitrequest = 1'b1;
      down_write     = 1'b0;

      // A burstcount of 0 is treated as a single line.
      if (up_burstcount == {IN_BURST_W{1'b0}}) begin
         rem_in_s = {{(CW-1){1'b0}}, 1'b1};
      end else begin
         rem_in_s = CW'(up_burstcount);
      end

      next_addr_s = addr_q + ADDR_WIDTH'(len_q);
      next_rem_s  = rem_q - len_q;
      beat_inc_s  = beat_q + {{(OUT_BURST_W-1){1'b0}}, 1'b1};
      last_sub_s  = (rem_q == len_q);

      case (state_q)
         IDLE: begin
            beat_d = {OUT_BURST_W{1'b0}};
            // Capture only; no beat is accepted here. Read wins a tie.
            if (up_read) begin
               addr_d  = up_address;
               rem_d   = rem_in_s;
               len_d   = sub_len(up_address[PAGE_LINES_LOG2-1:0], rem_in_s);
               state_d = RD_SPLIT;
            end else if (up_write) begin
               addr_d  = up_address;
               rem_d   = rem_in_s;
               len_d   = sub_len(up_address[PAGE_LINES_LOG2-1:0], rem_in_s);
               state_d = WR_SPLIT;
            end else begin
               state_d = IDLE;
            end
         end

         RD_SPLIT: begin
            if (!down_waitrequest) begin
               if (last_sub_s) begin
                  // Final command accepted: acknowledge the upstream read.
                  up_waitrequest = 1'b0;
                  state_d        = IDLE;
               end else begin
                  addr_d = next_addr_s;
                  rem_d  = next_rem_s;
                  len_d  = sub_len(next_addr_s[PAGE_LINES_LOG2-1:0], next_rem_s);
               end
            end else begin
               state_d = RD_SPLIT;
            end
         end

         WR_SPLIT: begin
            down_write     = up_write;
            up_waitrequest = down_waitrequest;
            if (up_write && !down_waitrequest) begin
               if (beat_inc_s == len_q[OUT_BURST_W-1:0]) begin
                  beat_d = {OUT_BURST_W{1'b0}};
                  if (last_sub_s) begin
                     state_d = IDLE;
                  end else begin
                     addr_d = next_addr_s;
                     rem_d  = next_rem_s;
                     len_d  = sub_len(next_addr_s[PAGE_LINES_LOG2-1:0], next_rem_s);
                  end
               end else begin
                  beat_d = beat_inc_s;
               end
            end else begin
               beat_d = beat_q;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      down_read_d = (state_d == RD_SPLIT);
   end

   // State and sub-burst registers with synchronous reset.
   always_ff @(posedge pClk) begin
      if (pClk_reset) begin
         state_q     <= IDLE;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         rem_q       <= {CW{1'b0}};
         len_q       <= {CW{1'b0}};
         beat_q      <= {OUT_BURST_W{1'b0}};
         down_read_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         down_read_q <= down_read_d;
      end
   end

   // Command outputs come straight from registers, so they stay stable
   // while the downstream slave stalls.
   assign down_address     = addr_q;
   assign down_burstcount  = len_q[OUT_BURST_W-1:0];
   assign down_read        = down_read_q;

   // Write data and read responses are pure pass-through.
   assign down_writedata   = up_writedata;
   assign down_byteenable  = up_byteenable;
   assign up_readdata      = down_readdata;
   assign up_readdatavalid = down_readdatavalid;

endmodule

// File: tb/tb_avmm_page_burst_splitter.sv
// ----------------------------------------------------------------------------
// Testbench for avmm_page_burst_splitter: directed upstream transactions,
// expected downstream commands / write beats / read data queued by the
// stimulus, and a negedge monitor that pops and compares them.
// ----------------------------------------------------------------------------
module tb_avmm_page_burst_splitter;

   localparam int AW  = 42;
   localparam int DW  = 512;
   localparam int BW  = DW / 8;
   localparam int IBW = 7;
   localparam int OBW = 6;

   logic           pClk = 1'b0;
   logic           pClk_reset = 1'b1;
   logic [AW-1:0]  up_address = '0;
   logic [IBW-1:0] up_burstcount = '0;
   logic           up_read = 1'b0;
   logic           up_write = 1'b0;
   logic [DW-1:0]  up_writedata = '0;
   logic [BW-1:0]  up_byteenable = '0;
   logic           up_waitrequest;
   logic [DW-1:0]  up_readdata;
   logic           up_readdatavalid;
   logic [AW-1:0]  down_address;
   logic [OBW-1:0] down_burstcount;
   logic           down_read;
   logic           down_write;
   logic [DW-1:0]  down_writedata;
   logic [BW-1:0]  down_byteenable;
   logic           down_waitrequest = 1'b0;
   logic [DW-1:0]  down_readdata = '0;
   logic           down_readdatavalid = 1'b0;

   avmm_page_burst_splitter dut (
      .pClk               (pClk),
      .pClk_reset         (pClk_reset),
      .up_address         (up_address),
      .up_burstcount      (up_burstcount),
      .up_read            (up_read),
      .up_write           (up_write),
      .up_writedata       (up_writedata),
      .up_byteenable      (up_byteenable),
      .up_waitrequest     (up_waitrequest),
      .up_readdata        (up_readdata),
      .up_readdatavalid   (up_readdatavalid),
      .down_address       (down_address),
      .down_burstcount    (down_burstcount),
      .down_read          (down_read),
      .down_write         (down_write),
      .down_writedata     (down_writedata),
      .down_byteenable    (down_byteenable),
      .down_waitrequest   (down_waitrequest),
      .down_readdata      (down_readdata),
      .down_readdatavalid (down_readdatavalid)
   );

   always #5 pClk = ~pClk;

   typedef struct {
      logic [AW-1:0] addr;
      int            len;
      bit            wr;
      bit            last;
   } cmd_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } wbeat_t;

   cmd_t          exp_cmd[$];
   wbeat_t        exp_wb[$];
   logic [DW-1:0] exp_rd[$];

   int n_cmp = 0;
   int n_err = 0;
   int rd_issued = 0;      // read lines commanded downstream
   int rd_returned = 0;    // read lines returned by the responder
   int rd_acc_total = 0;   // read commands accepted downstream
   int stall_base = 0;
   int wait_mode = 0;      // 0 none, 1 stall 2nd read sub-burst, 2 periodic, 3 forced
   int exp_rd_idx = 0;

   function automatic logic [DW-1:0] rd_word(input int i);
      logic [31:0] w;
      w = 32'hD000_0000 + 32'(i);
      return {16{w}};
   endfunction

   function automatic logic [DW-1:0] wr_word(input int i);
      logic [31:0] w;
      w = 32'h5A00_0000 + 32'(i);
      return {16{w}};
   endfunction

   function automatic logic [BW-1:0] be_word(input int i);
      return {BW{1'b1}} ^ BW'(i);
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_cmd(input logic [AW-1:0] addr, input int len, input bit wr, input bit last);
      cmd_t c;
      c.addr = addr; c.len = len; c.wr = wr; c.last = last;
      exp_cmd.push_back(c);
   endtask

   task automatic push_rd(input int n);
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(rd_word(exp_rd_idx));
         exp_rd_idx++;
      end
   endtask

   // Upstream read master: hold the command until up_waitrequest drops.
   task automatic do_read(input logic [AW-1:0] addr, input logic [IBW-1:0] bc, input bit also_write);
      bit done;
      int n;
      @(posedge pClk); #1;
      up_address = addr; up_burstcount = bc; up_read = 1'b1; up_write = also_write;
      @(negedge pClk);
      chk("rd_bubble_down_read", down_read, 1'b0);
      chk("rd_bubble_waitreq", up_waitrequest, 1'b1);
      done = 1'b0; n = 0;
      while (!done && n < 300) begin
         @(negedge pClk);
         n++;
         if (!up_waitrequest) done = 1'b1;
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL rd_timeout: got no accept expected accept within 300 cycles");
      end
      @(posedge pClk); #1;
      up_read = 1'b0; up_write = 1'b0;
   endtask

   // Upstream write master: send nbeats beats of a bc-long burst.
   task automatic do_write(input logic [AW-1:0] addr, input logic [IBW-1:0] bc,
                           input int nbeats, input int base, input bit keep);
      wbeat_t b;
      bit acc;
      int i;
      int n;
      for (int k = 0; k < nbeats; k++) begin
         b.data = wr_word(base + k); b.be = be_word(base + k);
         exp_wb.push_back(b);
      end
      @(posedge pClk); #1;
      up_address = addr; up_burstcount = bc; up_write = 1'b1;
      up_writedata = wr_word(base); up_byteenable = be_word(base);
      @(negedge pClk);
      chk("wr_bubble_down_write", down_write, 1'b0);
      chk("wr_bubble_waitreq", up_waitrequest, 1'b1);
      acc = 1'b0; i = 0; n = 0;
      while (1) begin
         @(posedge pClk); #1;
         if (acc) begin
            i++;
            if (i < nbeats) begin
               up_writedata = wr_word(base + i); up_byteenable = be_word(base + i);
            end
         end
         if (i >= nbeats || n >= 300) break;
         @(negedge pClk);
         n++;
         acc = !up_waitrequest;
      end
      if (i < nbeats) begin
         n_cmp++; n_err++;
         $display("FAIL wr_timeout: got %0d beats expected %0d", i, nbeats);
      end
      if (!keep) up_write = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_rd.size() != 0 || exp_cmd.size() != 0 || exp_wb.size() != 0) && n < 500) begin
         @(negedge pClk);
         n++;
      end
      n_cmp++;
      if (n >= 500) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d/%0d/%0d pending expected 0/0/0",
                  exp_cmd.size(), exp_wb.size(), exp_rd.size());
      end
   endtask

   // Downstream waitrequest generator, applied after the stimulus updates.
   int cyc = 0;
   int stall_done = 0;
   always @(posedge pClk) begin
      #2;
      cyc++;
      case (wait_mode)
         1: begin
            if ((rd_acc_total - stall_base) == 1 && stall_done < 5) begin
               down_waitrequest = 1'b1;
               stall_done++;
            end else begin
               down_waitrequest = 1'b0;
            end
         end
         2:       down_waitrequest = ((cyc % 3) == 1);
         3:       down_waitrequest = 1'b1;
         default: down_waitrequest = 1'b0;
      endcase
      if (wait_mode != 1) stall_done = 0;
   end

   // Downstream read responder: one line per cycle for every line commanded.
   always @(posedge pClk) begin
      #1;
      if (rd_returned < rd_issued) begin
         down_readdatavalid = 1'b1;
         down_readdata = rd_word(rd_returned);
         rd_returned++;
      end else begin
         down_readdatavalid = 1'b0;
      end
   end

   // Monitor / scoreboard.
   int            wr_beat = 0;
   int            cur_wlen = 1;
   bit            prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [OBW-1:0] prev_bc;
   cmd_t          mc;
   wbeat_t        mb;
   logic [DW-1:0] mr;
   always @(negedge pClk) begin
      if (pClk_reset) begin
         wr_beat = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_down_read", down_read, 1'b1);
            chk("stall_address", down_address, prev_addr);
            chk("stall_burstcount", down_burstcount, prev_bc);
         end
         if (down_read) begin
            if (!down_waitrequest) begin
               rd_acc_total++;
               rd_issued += int'(down_burstcount);
               if (exp_cmd.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_rd_cmd: got (%0h,%0d) expected none", down_address, down_burstcount);
               end else begin
                  mc = exp_cmd.pop_front();
                  chk("cmd_is_read", {31'd0, mc.wr}, 32'd0);
                  chk("rd_address", down_address, mc.addr);
                  chk("rd_burstcount", down_burstcount, mc.len);
                  chk("rd_accept_waitreq", up_waitrequest, !mc.last);
               end
            end else begin
               chk("rd_stall_waitreq", up_waitrequest, 1'b1);
            end
         end
         if (down_write) begin
            chk("wr_waitreq_mirror", up_waitrequest, down_waitrequest);
            if (!down_waitrequest) begin
               if (wr_beat == 0) begin
                  if (exp_cmd.size() == 0) begin
                     n_cmp++; n_err++;
                     $display("FAIL unexpected_wr_cmd: got (%0h,%0d) expected none", down_address, down_burstcount);
                     cur_wlen = 1;
                  end else begin
                     mc = exp_cmd.pop_front();
                     chk("cmd_is_write", {31'd0, mc.wr}, 32'd1);
                     chk("wr_address", down_address, mc.addr);
                     chk("wr_burstcount", down_burstcount, mc.len);
                     cur_wlen = mc.len;
                  end
               end
               if (exp_wb.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL unexpected_wr_beat: got %0h expected none", down_writedata[31:0]);
               end else begin
                  mb = exp_wb.pop_front();
                  chk("wr_data", down_writedata, mb.data);
                  chk("wr_byteenable", down_byteenable, mb.be);
               end
               wr_beat++;
               if (wr_beat >= cur_wlen) wr_beat = 0;
            end
         end
         if (up_readdatavalid) begin
            if (exp_rd.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_rd_data: got %0h expected none", up_readdata[31:0]);
            end else begin
               mr = exp_rd.pop_front();
               chk("rd_data", up_readdata, mr);
            end
         end
         prev_stall = down_read && down_waitrequest;
         prev_addr  = down_address;
         prev_bc    = down_burstcount;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state.
      pClk_reset = 1'b1;
      repeat (2) @(posedge pClk);
      @(negedge pClk);
      chk("rst_down_read", down_read, 1'b0);
      chk("rst_down_write", down_write, 1'b0);
      chk("rst_up_waitreq", up_waitrequest, 1'b1);
      @(posedge pClk); #1;
      pClk_reset = 1'b0;
      @(negedge pClk);
      chk("idle_down_read", down_read, 1'b0);
      chk("idle_up_waitreq", up_waitrequest, 1'b1);

      // 64-line read starting 4 lines before a page boundary.
      push_cmd(42'h3C, 4, 1'b0, 1'b0);
      push_cmd(42'h40, 32, 1'b0, 1'b0);
      push_cmd(42'h60, 28, 1'b0, 1'b1);
      push_rd(64);
      do_read(42'h3C, 7'd64, 1'b0);
      drain();

      // Single-line read.
      push_cmd(42'h0, 1, 1'b0, 1'b1);
      push_rd(1);
      do_read(42'h0, 7'd1, 1'b0);
      drain();

      // Read with the second sub-burst stalled for 5 cycles.
      stall_base = rd_acc_total;
      wait_mode = 1;
      push_cmd(42'h105, 32, 1'b0, 1'b0);
      push_cmd(42'h125, 8, 1'b0, 1'b1);
      push_rd(40);
      do_read(42'h105, 7'd40, 1'b0);
      drain();
      wait_mode = 0;

      // 8-beat write across a page boundary with periodic stalls.
      wait_mode = 2;
      push_cmd(42'h7E, 2, 1'b1, 1'b0);
      push_cmd(42'h80, 6, 1'b1, 1'b1);
      do_write(42'h7E, 7'd8, 8, 0, 1'b0);
      drain();
      wait_mode = 0;

      // Burstcount 0 is one line.
      push_cmd(42'h55, 1, 1'b0, 1'b1);
      push_rd(1);
      do_read(42'h55, 7'd0, 1'b0);
      drain();

      // Last line of a page first, then full sub-bursts.
      push_cmd(42'h3F, 1, 1'b0, 1'b0);
      push_cmd(42'h40, 32, 1'b0, 1'b0);
      push_cmd(42'h60, 31, 1'b0, 1'b1);
      push_rd(64);
      do_read(42'h3F, 7'd64, 1'b0);
      drain();

      // Read and write together: handled as read.
      push_cmd(42'h200, 2, 1'b0, 1'b1);
      push_rd(2);
      do_read(42'h200, 7'd2, 1'b1);
      drain();

      // Reset after 3 beats of an 8-beat write.
      push_cmd(42'h20, 8, 1'b1, 1'b1);
      do_write(42'h20, 7'd8, 3, 100, 1'b1);
      pClk_reset = 1'b1;
      wait_mode = 3;
      @(posedge pClk); #1;
      pClk_reset = 1'b0;
      wait_mode = 0;
      @(negedge pClk);
      chk("post_rst_down_write", down_write, 1'b0);
      chk("post_rst_down_read", down_read, 1'b0);
      chk("post_rst_up_waitreq", up_waitrequest, 1'b1);
      up_write = 1'b0;
      repeat (5) @(negedge pClk);
      push_cmd(42'h10, 4, 1'b0, 1'b1);
      push_rd(4);
      do_read(42'h10, 7'd4, 1'b0);
      drain();

      repeat (10) @(negedge pClk);
      chk("end_cmd_queue", 32'(exp_cmd.size()), 32'd0);
      chk("end_wbeat_queue", 32'(exp_wb.size()), 32'd0);
      chk("end_rdata_queue", 32'(exp_rd.size()), 32'd0);
      chk("end_rd_lines", 32'(rd_returned), 32'(exp_rd_idx));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
